// File: rtl/mskaes_128bits_round_ctrl_pkg.sv
// Shared encodings and round-constant table for the masked AES-128 round control.
package mskaes_128bits_round_ctrl_pkg;

  localparam int CNT_W   = 4;
  localparam int NROUNDS = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_IN = 2'd0,
    SEL_MC = 2'd1,
    SEL_SR = 2'd2
  } state_sel_e;

  typedef enum logic {
    KSEL_IN = 1'b0,
    KSEL_KS = 1'b1
  } key_sel_e;

  // Entry 0 is the first-round constant.
  localparam logic [NROUNDS-1:0][7:0] RC_TABLE = {
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
  };

  function automatic logic [7:0] rcon_lookup(input logic [CNT_W-1:0] idx);
    logic [7:0] rc;
    rc = 8'h00;
    for (int i = 0; i < NROUNDS; i++) begin
      if (idx == CNT_W'(i)) rc = RC_TABLE[i];
    end
    return rc;
  endfunction

endpackage

// File: rtl/mskaes_128bits_round_ctrl_if.sv
// Input/output valid-ready handshake of the round controller.
interface mskaes_128bits_round_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  modport master (output in_valid, output out_ready, input in_ready, input out_valid);
  modport slave  (input in_valid, input out_ready, output in_ready, output out_valid);
endinterface

// File: rtl/mskaes_rcon_rom.sv
// Combinational round-index to RCON lookup; indices past the last round give 00.
module mskaes_rcon_rom
  import mskaes_128bits_round_ctrl_pkg::*;
(
  input  logic [CNT_W-1:0] idx_i,
  output logic [7:0]       rcon_o
);
  assign rcon_o = rcon_lookup(idx_i);
endmodule

// File: rtl/mskaes_128bits_round_ctrl.sv
// Masked AES-128 round sequencer: 10 rounds of LATENCY cycles, output held under valid/ready.
// Optional RND_REQ_EN adds a registered rnd_req output that is high only in ROUND.
module mskaes_128bits_round_ctrl
  import mskaes_128bits_round_ctrl_pkg::*;
#(
  parameter int LATENCY = 4
)(
  input  logic                        clk,
  input  logic                        rst_n,
  mskaes_128bits_round_ctrl_if.slave  hs,
  output logic                        busy,
  output logic [1:0]                  state_sel,
  output logic                        state_en,
  output logic                        key_sel,
  output logic                        key_en,
  output logic [7:0]                  rcon,
  output logic [3:0]                  round_idx,
  output logic                        last_round
`ifdef RND_REQ_EN
  , output logic                      rnd_req
`endif
);

  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] RND_LAST = CNT_W'(NROUNDS - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cyc_q;
  logic [CNT_W-1:0] round_q;

  logic       in_rdy;
  logic       load;
  logic       rnd_end;
  logic       in_round;
  logic       is_last;
  logic [7:0] rc;

  mskaes_rcon_rom u_rcon (
    .idx_i  (round_q),
    .rcon_o (rc)
  );

  // Reset gates the load strobe so a held in_valid cannot fire enables during reset.
  always_comb begin
    in_round = (state_q == ST_ROUND);
    in_rdy   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && hs.out_ready);
    load     = in_rdy && hs.in_valid && rst_n;
    rnd_end  = in_round && (cyc_q == CYC_LAST);
    is_last  = in_round && (round_q == RND_LAST);
  end

  assign hs.in_ready  = in_rdy;
  assign hs.out_valid = (state_q == ST_DONE);
  assign busy         = in_round || (state_q == ST_DONE);
  assign state_en     = load || rnd_end;
  assign key_en       = load || rnd_end;
  assign state_sel    = rnd_end ? (is_last ? SEL_SR : SEL_MC) : SEL_IN;
  assign key_sel      = rnd_end ? KSEL_KS : KSEL_IN;
  assign rcon         = in_round ? rc : 8'h00;
  assign round_idx    = round_q;
  assign last_round   = is_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      round_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            state_q <= ST_ROUND;
            cyc_q   <= '0;
            round_q <= '0;
          end
        end
        ST_ROUND: begin
          if (rnd_end) begin
            cyc_q <= '0;
            if (is_last) begin
              state_q <= ST_DONE;
              round_q <= '0;
            end else begin
              round_q <= round_q + CNT_W'(1);
            end
          end else begin
            cyc_q <= cyc_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (load) begin
            state_q <= ST_ROUND;
            cyc_q   <= '0;
            round_q <= '0;
          end else if (hs.out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cyc_q   <= '0;
          round_q <= '0;
        end
      endcase
    end
  end

`ifdef RND_REQ_EN
  logic rnd_req_q;
  logic nxt_round;

  assign nxt_round = load || (in_round && !(rnd_end && is_last));

  always_ff @(posedge clk) begin
    if (!rst_n) rnd_req_q <= 1'b0;
    else        rnd_req_q <= nxt_round;
  end

  assign rnd_req = rnd_req_q;
`endif

endmodule
